// File: rtl/cache_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// cache_set_ctrl_if : core request/response port plus memory-side writeback
//                     and refill channels of one cache set
// Revision 1.0
// ============================================================================
interface cache_set_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     req_we;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic                     rsp_hit;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [ADDRESS_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     fill_req_valid;
  logic                     fill_req_ready;
  logic [ADDRESS_WIDTH-1:0] fill_addr;
  logic                     fill_valid;
  logic [DATA_WIDTH-1:0]    fill_data;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
           wb_ready, fill_req_ready, fill_valid, fill_data,
    output req_ready, rsp_valid, rsp_hit, rsp_rdata,
           wb_valid, wb_addr, wb_data, fill_req_valid, fill_addr
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
           wb_ready, fill_req_ready, fill_valid, fill_data,
    input  req_ready, rsp_valid, rsp_hit, rsp_rdata,
           wb_valid, wb_addr, wb_data, fill_req_valid, fill_addr
  );
endinterface
`default_nettype wire

// File: rtl/cache_set_ctrl.sv
`default_nettype none
// ============================================================================
// cache_set_ctrl : fully-associative cache set with LRU ages and a miss FSM
//                  (dirty writeback, refill) behind a handshaked memory port
// Revision 1.0
// ============================================================================
module cache_set_ctrl #(
  parameter int NUM_WAYS      = 4,
  parameter int BLOCK_WORDS   = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input logic             clk,
  input logic             reset_n,
  cache_set_ctrl_if.slave bus
);
  localparam int BYTE_BITS    = $clog2(DATA_WIDTH / 8);
  localparam int WORD_BITS    = $clog2(BLOCK_WORDS);
  localparam int OFFSET_WIDTH = BYTE_BITS + WORD_BITS;
  localparam int TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH;
  localparam int AGE_WIDTH    = $clog2(NUM_WAYS);
  localparam int CNT_W        = (WORD_BITS > 0) ? WORD_BITS : 1;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [AGE_WIDTH-1:0] OLDEST = AGE_WIDTH'(NUM_WAYS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WB   = 3'd1;
  localparam logic [2:0] S_FREQ = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [TAG_WIDTH-1:0]     tag_q   [NUM_WAYS];
  logic [AGE_WIDTH-1:0]     age_q   [NUM_WAYS];
  logic [DATA_WIDTH-1:0]    data_q  [NUM_WAYS][BLOCK_WORDS];
  logic [NUM_WAYS-1:0]      valid_q;
  logic [NUM_WAYS-1:0]      dirty_q;
  logic [TAG_WIDTH-1:0]     req_tag_q;
  logic [CNT_W-1:0]         req_word_q;
  logic                     req_we_q;
  logic [DATA_WIDTH-1:0]    req_wdata_q;
  logic [AGE_WIDTH-1:0]     victim_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     rsp_valid_q;
  logic                     rsp_hit_q;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q;

  logic                     accept;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic [CNT_W-1:0]         in_word;
  logic                     hit;
  logic [AGE_WIDTH-1:0]     hit_way;
  logic [AGE_WIDTH-1:0]     victim;
  logic                     touch_en;
  logic [AGE_WIDTH-1:0]     touch_way;
  logic [AGE_WIDTH-1:0]     touch_age;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign in_tag    = bus.req_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
  assign in_word   = CNT_W'((bus.req_addr >> BYTE_BITS) & ADDRESS_WIDTH'(BLOCK_WORDS - 1));
  assign touch_age = age_q[touch_way];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w] && (tag_q[w] == in_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_WIDTH'(w);
      end
    end
  end

  // The oldest way is the fallback; any invalid way (lowest index wins) overrides it.
  always_comb begin
    victim = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (age_q[w] == OLDEST) victim = AGE_WIDTH'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w]) victim = AGE_WIDTH'(w);
    end
  end

  always_comb begin
    touch_en  = 1'b0;
    touch_way = victim_q;
    if (accept && hit) begin
      touch_en  = 1'b1;
      touch_way = hit_way;
    end else if (state_q == S_RESP) begin
      touch_en  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && !hit)
                state_d = (valid_q[victim] && dirty_q[victim]) ? S_WB : S_FREQ;
      S_WB:   if (bus.wb_ready && (cnt_q == LAST_WORD)) state_d = S_FREQ;
      S_FREQ: if (bus.fill_req_ready) state_d = S_FILL;
      S_FILL: if (bus.fill_valid && (cnt_q == LAST_WORD)) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state_q == S_IDLE);
    bus.wb_valid       = (state_q == S_WB);
    bus.fill_req_valid = (state_q == S_FREQ);
    bus.wb_addr        = '0;
    bus.wb_data        = '0;
    bus.fill_addr      = '0;
    if (state_q == S_WB) begin
      bus.wb_addr = ADDRESS_WIDTH'(tag_q[victim_q]) << OFFSET_WIDTH;
      bus.wb_data = data_q[victim_q][cnt_q];
    end
    if (state_q == S_FREQ) bus.fill_addr = ADDRESS_WIDTH'(req_tag_q) << OFFSET_WIDTH;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_hit   = rsp_hit_q;
    bus.rsp_rdata = rsp_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        tag_q[w] <= '0;
        age_q[w] <= AGE_WIDTH'(w);
        for (int k = 0; k < BLOCK_WORDS; k++) data_q[w][k] <= '0;
      end
      valid_q     <= '0;
      dirty_q     <= '0;
      req_tag_q   <= '0;
      req_word_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (accept) begin
          if (hit) begin
            if (bus.req_we) begin
              data_q[hit_way][in_word] <= bus.req_wdata;
              dirty_q[hit_way]         <= 1'b1;
            end
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= 1'b1;
            rsp_rdata_q <= bus.req_we ? bus.req_wdata : data_q[hit_way][in_word];
          end else begin
            req_tag_q   <= in_tag;
            req_word_q  <= in_word;
            req_we_q    <= bus.req_we;
            req_wdata_q <= bus.req_wdata;
            victim_q    <= victim;
            cnt_q       <= '0;
          end
        end
        S_WB: if (bus.wb_ready) begin
          cnt_q <= (cnt_q == LAST_WORD) ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == LAST_WORD) dirty_q[victim_q] <= 1'b0;
        end
        S_FILL: if (bus.fill_valid) begin
          data_q[victim_q][cnt_q] <= bus.fill_data;
          cnt_q <= (cnt_q == LAST_WORD) ? '0 : cnt_q + CNT_W'(1);
        end
        S_RESP: begin
          tag_q[victim_q]   <= req_tag_q;
          valid_q[victim_q] <= 1'b1;
          dirty_q[victim_q] <= req_we_q;
          if (req_we_q) data_q[victim_q][req_word_q] <= req_wdata_q;
          rsp_valid_q <= 1'b1;
          rsp_hit_q   <= 1'b0;
          rsp_rdata_q <= req_we_q ? req_wdata_q : data_q[victim_q][req_word_q];
        end
        default: ;
      endcase
      // Ways younger than the touched one age by one; ages remain a permutation.
      if (touch_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (AGE_WIDTH'(w) == touch_way)   age_q[w] <= '0;
          else if (age_q[w] < touch_age)    age_q[w] <= age_q[w] + AGE_WIDTH'(1);
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cache_set_ctrl.sv
`default_nettype none
// tb_cache_set_ctrl: directed + randomized bench; reference model keeps the set as
// arrays plus a most-recent-first list of way numbers, backed by a word memory.
module tb_cache_set_ctrl;
  localparam int NW = 4;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cache_set_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();
  cache_set_ctrl #(.NUM_WAYS(NW), .BLOCK_WORDS(BW), .DATA_WIDTH(32), .ADDRESS_WIDTH(32))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  always #5 clk = ~clk;

  // reference model
  logic        m_valid [NW];
  logic        m_dirty [NW];
  logic [27:0] m_tag   [NW];
  logic [31:0] m_data  [NW][BW];
  int          lru[$];
  logic [31:0] mem [logic [31:0]];

  logic        exp_hit, exp_do_wb;
  logic [31:0] exp_rdata, exp_wb_addr, exp_fill_addr;
  logic [31:0] exp_wb_words [BW];

  // observations from the last driven access
  logic        obs_hit, obs_timeout, obs_pulse_err, obs_idle_ready, obs_fill_seen;
  logic [31:0] obs_rdata, obs_wb_addr, obs_fill_addr;
  logic [31:0] obs_wb_words [BW];
  int          obs_wb_cnt, obs_lat, obs_ready_err, obs_stable_err, obs_freq_cycles;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h3C5A_0000;
  endfunction

  function automatic void model_reset();
    lru.delete();
    for (int w = 0; w < NW; w++) begin
      m_valid[w] = 1'b0; m_dirty[w] = 1'b0; m_tag[w] = '0;
      for (int k = 0; k < BW; k++) m_data[w][k] = '0;
      lru.push_back(w);
    end
  endfunction

  function automatic int model_age(input int w);
    int r = -1;
    for (int i = 0; i < lru.size(); i++) if (lru[i] == w) r = i;
    return r;
  endfunction

  function automatic void model_access(input logic [31:0] a, input logic we, input logic [31:0] wd);
    int way = -1;
    int pos = -1;
    logic [27:0] tag = a[31:4];
    int word = int'(a[3:2]);
    for (int w = 0; w < NW; w++) if (m_valid[w] && m_tag[w] == tag) way = w;
    exp_hit = (way >= 0);
    exp_do_wb = 1'b0;
    exp_wb_addr = '0;
    exp_fill_addr = '0;
    if (!exp_hit) begin
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[w]) way = w;
      if (way < 0) way = lru[lru.size() - 1];
      if (m_valid[way] && m_dirty[way]) begin
        exp_do_wb = 1'b1;
        exp_wb_addr = {m_tag[way], 4'h0};
        for (int k = 0; k < BW; k++) begin
          exp_wb_words[k] = m_data[way][k];
          mem[exp_wb_addr + 32'(4 * k)] = m_data[way][k];
        end
      end
      exp_fill_addr = {tag, 4'h0};
      for (int k = 0; k < BW; k++) m_data[way][k] = mem_rd(exp_fill_addr + 32'(4 * k));
      m_tag[way] = tag; m_valid[way] = 1'b1; m_dirty[way] = 1'b0;
    end
    if (we) begin m_data[way][word] = wd; m_dirty[way] = 1'b1; end
    exp_rdata = m_data[way][word];
    for (int i = 0; i < lru.size(); i++) if (lru[i] == way) pos = i;
    if (pos >= 0) lru.delete(pos);
    lru.push_front(way);
  endfunction

  // Drives one request and acts as the memory side until the response pulse.
  task automatic run_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input int wb_stall, input int fr_stall, input bit gaps);
    int cyc = 0, wbw = 0, frw = 0, fsent = 0;
    bit factive = 0, wb_hold = 0, wb_seen = 0;
    logic [31:0] ld = '0;
    obs_wb_cnt = 0; obs_ready_err = 0; obs_stable_err = 0; obs_freq_cycles = 0;
    obs_fill_seen = 1'b0; obs_fill_addr = '0; obs_wb_addr = '0;
    for (int k = 0; k < BW; k++) obs_wb_words[k] = '0;
    @(negedge clk);
    obs_pulse_err  = bus.rsp_valid;
    obs_idle_ready = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_we = we; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 300) begin
      if (bus.req_ready) obs_ready_err++;
      bus.wb_ready = 1'b0;
      if (bus.wb_valid) begin
        if (!wb_seen) begin wb_seen = 1; obs_wb_addr = bus.wb_addr; end
        else if (bus.wb_addr !== obs_wb_addr) obs_stable_err++;
        if (wb_hold && bus.wb_data !== ld) obs_stable_err++;
        if (wbw < wb_stall || (gaps && $urandom_range(0, 3) == 0)) begin
          wbw++; wb_hold = 1; ld = bus.wb_data;
        end else begin
          bus.wb_ready = 1'b1; wb_hold = 0;
          if (obs_wb_cnt < BW) obs_wb_words[obs_wb_cnt] = bus.wb_data;
          obs_wb_cnt++;
        end
      end
      bus.fill_req_ready = 1'b0;
      if (bus.fill_req_valid) begin
        if (!obs_fill_seen) begin obs_fill_seen = 1'b1; obs_fill_addr = bus.fill_addr; end
        else if (bus.fill_addr !== obs_fill_addr) obs_stable_err++;
        obs_freq_cycles++;
        if (frw < fr_stall) frw++;
        else bus.fill_req_ready = 1'b1;
      end
      if (factive && fsent < BW) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          bus.fill_valid = 1'b0; bus.fill_data = $urandom;
        end else begin
          bus.fill_valid = 1'b1; bus.fill_data = mem_rd(obs_fill_addr + 32'(4 * fsent)); fsent++;
        end
      end else begin
        bus.fill_valid = 1'($urandom_range(0, 1)); bus.fill_data = $urandom;
      end
      if (bus.fill_req_ready) factive = 1;
      @(negedge clk);
      cyc++;
    end
    bus.wb_ready = 1'b0; bus.fill_req_ready = 1'b0; bus.fill_valid = 1'b0;
    obs_timeout = !bus.rsp_valid;
    obs_hit = bus.rsp_hit; obs_rdata = bus.rsp_rdata; obs_lat = cyc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.wb_valid !== 1'b0 || bus.fill_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got rdy=%b rsp=%b wb=%b freq=%b want 1 0 0 0", bus.req_ready, bus.rsp_valid, bus.wb_valid, bus.fill_req_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_hit !== 1'b0 || bus.wb_addr !== 32'h0 || bus.wb_data !== 32'h0 || bus.fill_addr !== 32'h0) begin
      errors++; $display("FAIL reset_data: got rdata=%h hit=%b wba=%h wbd=%h fa=%h want all 0", bus.rsp_rdata, bus.rsp_hit, bus.wb_addr, bus.wb_data, bus.fill_addr); end
    reset_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < NW; w++) begin
      checks++; if (int'(dut.age_q[w]) !== model_age(w)) begin
        errors++; $display("FAIL reset_age way%0d: got %0d want %0d", w, dut.age_q[w], model_age(w)); end
    end
  endtask

  task automatic test_first_miss();
    model_access(32'h100, 1'b0, 32'h0);
    run_access(32'h100, 1'b0, 32'h0, 0, 0, 1'b0);
    checks++; if (obs_timeout || obs_hit !== 1'b0 || obs_rdata !== 32'hA0 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL first_miss rsp: got to=%b hit=%b rdata=%h want 0 0 000000a0", obs_timeout, obs_hit, obs_rdata); end
    checks++; if (obs_wb_cnt !== 0 || obs_fill_addr !== 32'h100) begin
      errors++; $display("FAIL first_miss mem: got wb=%0d fill_addr=%h want 0 00000100", obs_wb_cnt, obs_fill_addr); end
    checks++; if (dut.valid_q[0] !== 1'b1 || int'(dut.age_q[0]) !== model_age(0)) begin
      errors++; $display("FAIL first_miss way0: got valid=%b age=%0d want 1 %0d", dut.valid_q[0], dut.age_q[0], model_age(0)); end
  endtask

  task automatic test_hit();
    model_access(32'h104, 1'b0, 32'h0);
    run_access(32'h104, 1'b0, 32'h0, 0, 0, 1'b0);
    checks++; if (obs_timeout || obs_lat !== 1 || obs_hit !== 1'b1 || obs_rdata !== 32'hA1) begin
      errors++; $display("FAIL read_hit: got to=%b lat=%0d hit=%b rdata=%h want 0 1 1 000000a1", obs_timeout, obs_lat, obs_hit, obs_rdata); end
    checks++; if (obs_wb_cnt !== 0 || obs_fill_seen !== 1'b0 || obs_pulse_err !== 1'b0) begin
      errors++; $display("FAIL read_hit traffic: got wb=%0d fill=%b prev_rsp=%b want 0 0 0", obs_wb_cnt, obs_fill_seen, obs_pulse_err); end
  endtask

  task automatic test_write_hit();
    model_access(32'h108, 1'b1, 32'hDEAD_BEEF);
    run_access(32'h108, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0);
    checks++; if (obs_timeout || obs_hit !== 1'b1 || obs_rdata !== 32'hDEAD_BEEF || dut.dirty_q[0] !== 1'b1) begin
      errors++; $display("FAIL write_hit: got to=%b hit=%b rdata=%h dirty=%b want 0 1 deadbeef 1", obs_timeout, obs_hit, obs_rdata, dut.dirty_q[0]); end
    model_access(32'h108, 1'b0, 32'h0);
    run_access(32'h108, 1'b0, 32'h0, 0, 0, 1'b0);
    checks++; if (obs_hit !== 1'b1 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL write_readback: got hit=%b rdata=%h want 1 %h", obs_hit, obs_rdata, exp_rdata); end
  endtask

  task automatic test_eviction();
    logic [31:0] seq [6] = '{32'h200, 32'h300, 32'h400, 32'h204, 32'h304, 32'h404};
    for (int i = 0; i < 6; i++) begin
      model_access(seq[i], 1'b0, 32'h0);
      run_access(seq[i], 1'b0, 32'h0, 0, 0, 1'b0);
      checks++; if (obs_timeout || obs_hit !== exp_hit || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL fill_ways %h: got hit=%b rdata=%h want %b %h", seq[i], obs_hit, obs_rdata, exp_hit, exp_rdata); end
    end
    model_access(32'h500, 1'b0, 32'h0);
    run_access(32'h500, 1'b0, 32'h0, 3, 2, 1'b0);
    checks++; if (obs_wb_cnt !== 4 || obs_wb_addr !== 32'h100 || obs_wb_addr !== exp_wb_addr) begin
      errors++; $display("FAIL evict_wb: got words=%0d addr=%h want 4 00000100", obs_wb_cnt, obs_wb_addr); end
    checks++; if (obs_wb_words[0] !== 32'hA0 || obs_wb_words[1] !== 32'hA1 || obs_wb_words[2] !== 32'hDEAD_BEEF || obs_wb_words[3] !== 32'hA3) begin
      errors++; $display("FAIL evict_wb_data: got %h %h %h %h want a0 a1 deadbeef a3", obs_wb_words[0], obs_wb_words[1], obs_wb_words[2], obs_wb_words[3]); end
    checks++; if (obs_fill_addr !== 32'h500 || obs_freq_cycles !== 3 || obs_hit !== 1'b0 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL evict_fill: got fa=%h freq_cyc=%0d hit=%b rdata=%h want 00000500 3 0 %h", obs_fill_addr, obs_freq_cycles, obs_hit, obs_rdata, exp_rdata); end
    checks++; if (obs_stable_err !== 0 || obs_ready_err !== 0) begin
      errors++; $display("FAIL evict_stall: got unstable=%0d busy_ready=%0d want 0 0", obs_stable_err, obs_ready_err); end
  endtask

  task automatic test_back_to_back();
    logic h0, h1;
    logic [31:0] r0, r1;
    model_access(32'h50C, 1'b1, 32'hCAFE_F00D); h0 = exp_hit; r0 = exp_rdata;
    model_access(32'h304, 1'b0, 32'h0);         h1 = exp_hit; r1 = exp_rdata;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h50C; bus.req_we = 1'b1; bus.req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== h0 || bus.rsp_rdata !== r0) begin
      errors++; $display("FAIL b2b_first: got v=%b hit=%b rdata=%h want 1 %b %h", bus.rsp_valid, bus.rsp_hit, bus.rsp_rdata, h0, r0); end
    bus.req_addr = 32'h304; bus.req_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== h1 || bus.rsp_rdata !== r1) begin
      errors++; $display("FAIL b2b_second: got v=%b hit=%b rdata=%h want 1 %b %h", bus.rsp_valid, bus.rsp_hit, bus.rsp_rdata, h1, r1); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_pulse: got rsp_valid=%b want 0", bus.rsp_valid); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic we;
    for (int n = 0; n < 120; n++) begin
      a  = (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 3)) << 2);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      model_access(a, we, wd);
      run_access(a, we, wd, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      checks++; if (obs_timeout || obs_hit !== exp_hit || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL rand%0d rsp a=%h we=%b: got to=%b hit=%b rdata=%h want 0 %b %h", n, a, we, obs_timeout, obs_hit, obs_rdata, exp_hit, exp_rdata); end
      checks++; if (obs_wb_cnt !== (exp_do_wb ? BW : 0) || (exp_do_wb && obs_wb_addr !== exp_wb_addr)) begin
        errors++; $display("FAIL rand%0d wb: got words=%0d addr=%h want %0d %h", n, obs_wb_cnt, obs_wb_addr, exp_do_wb ? BW : 0, exp_wb_addr); end
      if (exp_do_wb) begin
        for (int k = 0; k < BW; k++) begin
          checks++; if (obs_wb_words[k] !== exp_wb_words[k]) begin
            errors++; $display("FAIL rand%0d wb_word%0d: got %h want %h", n, k, obs_wb_words[k], exp_wb_words[k]); end
        end
      end
      checks++; if (obs_fill_seen !== !exp_hit || (!exp_hit && obs_fill_addr !== exp_fill_addr) || (exp_hit && obs_lat !== 1)) begin
        errors++; $display("FAIL rand%0d fill: got seen=%b fa=%h lat=%0d want %b %h", n, obs_fill_seen, obs_fill_addr, obs_lat, !exp_hit, exp_fill_addr); end
      checks++; if (obs_stable_err !== 0 || obs_ready_err !== 0 || obs_pulse_err !== 1'b0 || obs_idle_ready !== 1'b1) begin
        errors++; $display("FAIL rand%0d handshake: got unstable=%0d busy_ready=%0d prev_rsp=%b idle_ready=%b want 0 0 0 1", n, obs_stable_err, obs_ready_err, obs_pulse_err, obs_idle_ready); end
    end
    for (int w = 0; w < NW; w++) begin
      checks++; if (int'(dut.age_q[w]) !== model_age(w) || dut.valid_q[w] !== m_valid[w]) begin
        errors++; $display("FAIL rand_state way%0d: got age=%0d valid=%b want %0d %b", w, dut.age_q[w], dut.valid_q[w], model_age(w), m_valid[w]); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int cyc = 0, fsent = 0;
    bit factive = 0, done = 0;
    model_access(32'h700, 1'b0, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h700; bus.req_we = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!done && cyc < 100) begin
      bus.wb_ready = bus.wb_valid;
      bus.fill_req_ready = bus.fill_req_valid;
      bus.fill_valid = 1'b0;
      if (factive) begin
        bus.fill_valid = 1'b1; bus.fill_data = mem_rd(32'h700 + 32'(4 * fsent));
        if (fsent == 2) begin #2 reset_n = 1'b0; done = 1; end
        fsent++;
      end
      if (bus.fill_req_ready) factive = 1;
      if (!done) begin @(negedge clk); cyc++; end
    end
    checks++; if (!done) begin
      errors++; $display("FAIL reset_mid_fill reach: got fill words=%0d want 3", fsent); end
    #1;
    bus.fill_valid = 1'b0; bus.wb_ready = 1'b0; bus.fill_req_ready = 1'b0;
    model_reset();
    checks++; if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.fill_req_valid !== 1'b0 || dut.valid_q !== 4'b0000 || dut.dirty_q !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_fill state: got rdy=%b wb=%b freq=%b valid=%b dirty=%b want 1 0 0 0000 0000", bus.req_ready, bus.wb_valid, bus.fill_req_valid, dut.valid_q, dut.dirty_q); end
    for (int w = 0; w < NW; w++) begin
      checks++; if (int'(dut.age_q[w]) !== model_age(w)) begin
        errors++; $display("FAIL reset_mid_fill age way%0d: got %0d want %0d", w, dut.age_q[w], model_age(w)); end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_after_reset();
    model_access(32'h108, 1'b0, 32'h0);
    run_access(32'h108, 1'b0, 32'h0, 0, 1, 1'b0);
    checks++; if (obs_timeout || obs_hit !== 1'b0 || obs_wb_cnt !== 0 || obs_fill_addr !== 32'h100 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL after_reset: got to=%b hit=%b wb=%0d fa=%h rdata=%h want 0 0 0 00000100 %h", obs_timeout, obs_hit, obs_wb_cnt, obs_fill_addr, obs_rdata, exp_rdata); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_wdata = '0;
    bus.wb_ready = 1'b0; bus.fill_req_ready = 1'b0; bus.fill_valid = 1'b0; bus.fill_data = '0;
    mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1; mem[32'h108] = 32'hA2; mem[32'h10C] = 32'hA3;
    model_reset();
    test_reset();
    test_first_miss();
    test_hit();
    test_write_hit();
    test_eviction();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    test_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
